mem_req_initiator: RTL and testbench
====================================

Name: mem_req_initiator

Overview:
Bus-master side of the memory request/response interface served by the peripheral register and memory devices.
- Accepts one load/store command at a time from the pipeline over a valid/ready handshake.
- Drives a single-cycle request (addr, wr_data, wr_en, count) to the responder, then waits for the registered response code.
- Sign- or zero-extends read data and returns a one-cycle completion pulse with data and code.
- Enforces a response timeout so a missing or unmapped responder cannot hang the pipeline.

Parameters:
TIMEOUT, 4, max WAIT cycles sampling a non-response before forced completion; legal range 1..255.

Ports:
clk  input  1  clock, all state on rising edge
aresetn  input  1  asynchronous active-low reset
i_cmd_valid  input  1  command present
o_cmd_ready  output  1  high only in IDLE; command accepted when valid && ready
i_cmd_addr  input  `ADDR_W  byte address
i_cmd_wr_data  input  `WORD_W  store data, unshifted and low-aligned
i_cmd_wr_en  input  1  1=store, 0=load
i_cmd_count  input  `MEM_COUNT_W  `MEM_COUNT_NONE/BYTE/HALF/WORD
i_cmd_signed  input  1  loads only: 1=sign-extend, 0=zero-extend
o_req_addr  output  `ADDR_W  request address to responder
o_req_wr_data  output  `WORD_W  request write data
o_req_wr_en  output  1  request write enable
o_req_count  output  `MEM_COUNT_W  request size; `MEM_COUNT_NONE when idle
i_res_rd_data  input  `WORD_W  responder read data, low-aligned
i_res_code  input  `MEM_CODE_W  responder code; `MEM_CODE_INVALID = no response
o_done  output  1  one-cycle completion pulse
o_rd_data  output  `WORD_W  extended load result
o_code  output  `MEM_CODE_W  final response code
o_timeout  output  1  qualifies o_done: completion was forced by timeout

Behaviour:
- Reset (async, aresetn=0):
  - state IDLE, wait counter 0.
  - o_req_addr, o_req_wr_data, o_req_wr_en = 0; o_req_count = `MEM_COUNT_NONE.
  - o_done = 0, o_rd_data = 0, o_code = `MEM_CODE_INVALID, o_timeout = 0.
- Reset mid-operation aborts the transaction: no o_done, request bus returns to NONE immediately.
- All outputs are registered except o_cmd_ready, which is decoded from state (ready = state==IDLE).
- FSM has three states: IDLE, REQ, WAIT.
- IDLE:
  - On accept with count != NONE: latch command (addr, wr_data, wr_en, count, signed), load o_req_*, go to REQ.
  - On accept with count == NONE: no bus request. Next cycle o_done=1, o_code=`MEM_CODE_INVALID, o_rd_data=0, o_timeout=0. Stay in IDLE.
- REQ:
  - Lasts exactly one cycle with o_req_count = latched count; the responder samples the request at the end of this cycle.
  - Next edge: o_req_count <= NONE, counter <= 0, go to WAIT.
  - Request is never repeated, so writes execute exactly once.
- WAIT: each cycle, sample i_res_code.
  - Code != `MEM_CODE_INVALID: complete on the next edge with o_done=1 and o_code=i_res_code, then go to IDLE.
  - Load with code `MEM_CODE_READ: o_rd_data per extension rules below.
  - Any other code: o_rd_data=0.
  - Code == INVALID and counter == TIMEOUT-1: complete with o_code=`MEM_CODE_INVALID, o_rd_data=0, o_timeout=1, then go to IDLE.
  - Otherwise counter increments.
- Extension (uses the latched count and signed flag):
  - BYTE: bits [7:0], upper bits = signed ? bit7 : 0.
  - HALF: bits [15:0], upper bits = signed ? bit15 : 0.
  - WORD: pass-through; the signed flag is ignored.
- Latency against a 1-cycle responder:
  - Accept at edge 0, request visible in cycle 1, response visible in cycle 2, o_done high in cycle 3.
  - Next command can be accepted in cycle 3, so back-to-back throughput is one transaction per 3 cycles.
- o_done is high for exactly one cycle. o_rd_data, o_code and o_timeout hold until the next completion.
- i_cmd_* is ignored while o_cmd_ready=0.
- No local alignment or bounds checks: the responder's MISALIGNED/OUT_OF_BOUNDS codes are forwarded unchanged.

Test Plan:
1. Store WORD addr 0x8 data 0xDEADBEEF -> o_req_count=WORD for exactly 1 cycle; o_done in cycle 3 with o_code=`MEM_CODE_WRITE, o_rd_data=0.
2. Signed BYTE load addr 0xB after test 1 -> o_rd_data=0xFFFFFFDE, o_code=`MEM_CODE_READ. Same load unsigned -> 0x000000DE.
3. Unsigned HALF load addr 0xA -> 0x0000DEAD. Signed HALF load addr 0x8 -> 0xFFFFBEEF.
4. WORD load addr 0x2 -> o_code=`MEM_CODE_MISALIGNED, o_rd_data=0, o_timeout=0. Command with count NONE -> o_done next cycle, code INVALID, o_req_count stays NONE throughout.
5. i_res_code tied INVALID, TIMEOUT=4 -> o_done after 4 WAIT cycles (cycle 6 from accept), o_timeout=1; o_cmd_ready high again in the same cycle.
6. aresetn pulsed low during WAIT -> outputs return to reset values immediately, no o_done. i_cmd_valid held high across two commands -> second accepted exactly in the o_done cycle of the first.

Source files
------------

// File: rtl/mem_req_initiator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_req_initiator
// Purpose  : Bus-master side of the memory request/response interface.
//            Takes one load/store command at a time from the pipeline,
//            issues a single-cycle request to the responder, waits for the
//            registered response code and returns a one-cycle completion
//            pulse with extended read data. A response timeout keeps a
//            missing or unmapped responder from hanging the pipeline.
// Ports    : clk, aresetn           - clock / async active-low reset
//            i_cmd_* / o_cmd_ready  - command valid/ready handshake
//            o_req_*                - request bus to the responder
//            i_res_*                - responder read data and code
//            o_done, o_rd_data,
//            o_code, o_timeout      - completion pulse and held results
// Revision : 1.0 - initial release
// ============================================================================

`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef WORD_W
`define WORD_W 32
`endif
`ifndef MEM_COUNT_W
`define MEM_COUNT_W 2
`define MEM_COUNT_NONE 2'd0
`define MEM_COUNT_BYTE 2'd1
`define MEM_COUNT_HALF 2'd2
`define MEM_COUNT_WORD 2'd3
`endif
`ifndef MEM_CODE_W
`define MEM_CODE_W 3
`define MEM_CODE_INVALID       3'd0
`define MEM_CODE_READ          3'd1
`define MEM_CODE_WRITE         3'd2
`define MEM_CODE_MISALIGNED    3'd3
`define MEM_CODE_OUT_OF_BOUNDS 3'd4
`endif

module mem_req_initiator #(
    parameter int unsigned TIMEOUT = 4
) (
    input  logic                    clk,
    input  logic                    aresetn,
    input  logic                    i_cmd_valid,
    output logic                    o_cmd_ready,
    input  logic [`ADDR_W-1:0]      i_cmd_addr,
    input  logic [`WORD_W-1:0]      i_cmd_wr_data,
    input  logic                    i_cmd_wr_en,
    input  logic [`MEM_COUNT_W-1:0] i_cmd_count,
    input  logic                    i_cmd_signed,
    output logic [`ADDR_W-1:0]      o_req_addr,
    output logic [`WORD_W-1:0]      o_req_wr_data,
    output logic                    o_req_wr_en,
    output logic [`MEM_COUNT_W-1:0] o_req_count,
    input  logic [`WORD_W-1:0]      i_res_rd_data,
    input  logic [`MEM_CODE_W-1:0]  i_res_code,
    output logic                    o_done,
    output logic [`WORD_W-1:0]      o_rd_data,
    output logic [`MEM_CODE_W-1:0]  o_code,
    output logic                    o_timeout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    // Last counter value before a silent responder is declared absent.
    localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [7:0]              r_wait_cnt;
    logic [7:0]              w_wait_cnt_nxt;
    // Size and signedness survive the request cycle; o_req_count does not.
    logic [`MEM_COUNT_W-1:0] r_count;
    logic [`MEM_COUNT_W-1:0] w_count_nxt;
    logic                    r_signed;
    logic                    w_signed_nxt;

    logic [`ADDR_W-1:0]      w_req_addr_nxt;
    logic [`WORD_W-1:0]      w_req_wr_data_nxt;
    logic                    w_req_wr_en_nxt;
    logic [`MEM_COUNT_W-1:0] w_req_count_nxt;
    logic                    w_done_nxt;
    logic [`WORD_W-1:0]      w_rd_data_nxt;
    logic [`MEM_CODE_W-1:0]  w_code_nxt;
    logic                    w_timeout_nxt;

    function automatic logic [`WORD_W-1:0] f_extend(
        input logic [`WORD_W-1:0]      d,
        input logic [`MEM_COUNT_W-1:0] cnt,
        input logic                    sgn
    );
        logic [`WORD_W-1:0] r;
        case (cnt)
            `MEM_COUNT_BYTE: r = {{(`WORD_W-8){sgn & d[7]}}, d[7:0]};
            `MEM_COUNT_HALF: r = {{(`WORD_W-16){sgn & d[15]}}, d[15:0]};
            default:         r = d;
        endcase
        return r;
    endfunction

    assign o_cmd_ready = (r_state == S_IDLE);

    always_comb begin
        w_state_nxt       = r_state;
        w_wait_cnt_nxt    = r_wait_cnt;
        w_count_nxt       = r_count;
        w_signed_nxt      = r_signed;
        w_req_addr_nxt    = o_req_addr;
        w_req_wr_data_nxt = o_req_wr_data;
        w_req_wr_en_nxt   = o_req_wr_en;
        w_req_count_nxt   = o_req_count;
        w_done_nxt        = 1'b0;
        w_rd_data_nxt     = o_rd_data;
        w_code_nxt        = o_code;
        w_timeout_nxt     = o_timeout;

        case (r_state)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    if (i_cmd_count != `MEM_COUNT_NONE) begin
                        w_req_addr_nxt    = i_cmd_addr;
                        w_req_wr_data_nxt = i_cmd_wr_data;
                        w_req_wr_en_nxt   = i_cmd_wr_en;
                        w_req_count_nxt   = i_cmd_count;
                        w_count_nxt       = i_cmd_count;
                        w_signed_nxt      = i_cmd_signed;
                        w_state_nxt       = S_REQ;
                    end else begin
                        // Zero-size command: complete locally, no bus traffic.
                        w_done_nxt    = 1'b1;
                        w_code_nxt    = `MEM_CODE_INVALID;
                        w_rd_data_nxt = '0;
                        w_timeout_nxt = 1'b0;
                    end
                end
            end
            S_REQ: begin
                // Request is shown for one cycle only so writes happen once.
                w_req_count_nxt = `MEM_COUNT_NONE;
                w_wait_cnt_nxt  = 8'd0;
                w_state_nxt     = S_WAIT;
            end
            S_WAIT: begin
                if (i_res_code != `MEM_CODE_INVALID) begin
                    w_done_nxt    = 1'b1;
                    w_code_nxt    = i_res_code;
                    w_timeout_nxt = 1'b0;
                    if (!o_req_wr_en && (i_res_code == `MEM_CODE_READ)) begin
                        w_rd_data_nxt = f_extend(i_res_rd_data, r_count, r_signed);
                    end else begin
                        w_rd_data_nxt = '0;
                    end
                    w_state_nxt = S_IDLE;
                end else if (r_wait_cnt == c_TIMEOUT_LAST) begin
                    w_done_nxt    = 1'b1;
                    w_code_nxt    = `MEM_CODE_INVALID;
                    w_rd_data_nxt = '0;
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                end
            end
            default: begin
                w_req_count_nxt = `MEM_COUNT_NONE;
                w_state_nxt     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state       <= S_IDLE;
            r_wait_cnt    <= 8'd0;
            r_count       <= `MEM_COUNT_NONE;
            r_signed      <= 1'b0;
            o_req_addr    <= '0;
            o_req_wr_data <= '0;
            o_req_wr_en   <= 1'b0;
            o_req_count   <= `MEM_COUNT_NONE;
            o_done        <= 1'b0;
            o_rd_data     <= '0;
            o_code        <= `MEM_CODE_INVALID;
            o_timeout     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_wait_cnt    <= w_wait_cnt_nxt;
            r_count       <= w_count_nxt;
            r_signed      <= w_signed_nxt;
            o_req_addr    <= w_req_addr_nxt;
            o_req_wr_data <= w_req_wr_data_nxt;
            o_req_wr_en   <= w_req_wr_en_nxt;
            o_req_count   <= w_req_count_nxt;
            o_done        <= w_done_nxt;
            o_rd_data     <= w_rd_data_nxt;
            o_code        <= w_code_nxt;
            o_timeout     <= w_timeout_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_req_initiator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_req_initiator
// Purpose  : Self-checking bench for mem_req_initiator. A byte-addressed
//            responder (64 bytes, registered response, alignment and bounds
//            checks, optional mute) serves the DUT; expected results come from
//            a vector table, hand sequences and a byte-array reference model.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef WORD_W
`define WORD_W 32
`endif
`ifndef MEM_COUNT_W
`define MEM_COUNT_W 2
`define MEM_COUNT_NONE 2'd0
`define MEM_COUNT_BYTE 2'd1
`define MEM_COUNT_HALF 2'd2
`define MEM_COUNT_WORD 2'd3
`endif
`ifndef MEM_CODE_W
`define MEM_CODE_W 3
`define MEM_CODE_INVALID       3'd0
`define MEM_CODE_READ          3'd1
`define MEM_CODE_WRITE         3'd2
`define MEM_CODE_MISALIGNED    3'd3
`define MEM_CODE_OUT_OF_BOUNDS 3'd4
`endif

module tb_mem_req_initiator;

    localparam int TIMEOUT   = 4;
    localparam int MEM_BYTES = 64;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        i_cmd_valid = 1'b0;
    logic        o_cmd_ready;
    logic [31:0] i_cmd_addr = '0;
    logic [31:0] i_cmd_wr_data = '0;
    logic        i_cmd_wr_en = 1'b0;
    logic [1:0]  i_cmd_count = '0;
    logic        i_cmd_signed = 1'b0;
    logic [31:0] o_req_addr;
    logic [31:0] o_req_wr_data;
    logic        o_req_wr_en;
    logic [1:0]  o_req_count;
    logic [31:0] i_res_rd_data;
    logic [2:0]  i_res_code;
    logic        o_done;
    logic [31:0] o_rd_data;
    logic [2:0]  o_code;
    logic        o_timeout;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_req_initiator #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .aresetn(aresetn),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_addr(i_cmd_addr), .i_cmd_wr_data(i_cmd_wr_data),
        .i_cmd_wr_en(i_cmd_wr_en), .i_cmd_count(i_cmd_count),
        .i_cmd_signed(i_cmd_signed),
        .o_req_addr(o_req_addr), .o_req_wr_data(o_req_wr_data),
        .o_req_wr_en(o_req_wr_en), .o_req_count(o_req_count),
        .i_res_rd_data(i_res_rd_data), .i_res_code(i_res_code),
        .o_done(o_done), .o_rd_data(o_rd_data), .o_code(o_code),
        .o_timeout(o_timeout)
    );

    // ------------------------------------------------------------------
    // Responder: registered, one-cycle latency, garbage on unused data.
    // ------------------------------------------------------------------
    logic [7:0] rmem [0:MEM_BYTES-1];
    logic       mute = 1'b0;

    function automatic int size_of(input logic [1:0] c);
        return 1 << (int'(c) - 1);
    endfunction

    function automatic logic [31:0] rsp_read(input logic [31:0] a, input int sz);
        logic [31:0] v;
        v = $urandom;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = rmem[a + i];
        return v;
    endfunction

    always @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            i_res_code    <= `MEM_CODE_INVALID;
            i_res_rd_data <= '0;
            for (int i = 0; i < MEM_BYTES; i++) rmem[i] <= 8'h00;
        end else if (o_req_count == `MEM_COUNT_NONE || mute) begin
            i_res_code    <= `MEM_CODE_INVALID;
            i_res_rd_data <= $urandom;
        end else if ((o_req_addr % size_of(o_req_count)) != 0) begin
            i_res_code    <= `MEM_CODE_MISALIGNED;
            i_res_rd_data <= $urandom;
        end else if (o_req_addr + size_of(o_req_count) > MEM_BYTES) begin
            i_res_code    <= `MEM_CODE_OUT_OF_BOUNDS;
            i_res_rd_data <= $urandom;
        end else if (o_req_wr_en) begin
            for (int i = 0; i < 4; i++)
                if (i < size_of(o_req_count)) rmem[o_req_addr + i] <= o_req_wr_data[8*i +: 8];
            i_res_code    <= `MEM_CODE_WRITE;
            i_res_rd_data <= $urandom;
        end else begin
            i_res_code    <= `MEM_CODE_READ;
            i_res_rd_data <= rsp_read(o_req_addr, size_of(o_req_count));
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Issues one command and observes it to completion. lat counts clock
    // edges after the accepting edge until o_done is seen.
    task automatic run_cmd(
        input  logic        wr, input logic [1:0] cnt, input logic sgn,
        input  logic [31:0] addr, input logic [31:0] data,
        output logic [2:0]  code, output logic [31:0] rd, output logic to,
        output int lat, output int req_cycles,
        output logic rdy_at_done, output logic hold_ok, output logic req_ok
    );
        int g;
        g = 0;
        @(negedge clk);
        while (!o_cmd_ready && g < 50) begin @(negedge clk); g++; end
        i_cmd_wr_en = wr; i_cmd_count = cnt; i_cmd_signed = sgn;
        i_cmd_addr = addr; i_cmd_wr_data = data; i_cmd_valid = 1'b1;
        @(posedge clk); #1;
        i_cmd_valid   = 1'b0;
        i_cmd_addr    = $urandom;
        i_cmd_wr_data = $urandom;
        i_cmd_count   = 2'($urandom);
        lat = 0; req_cycles = 0; req_ok = 1'b1;
        while (1) begin
            if (o_req_count != `MEM_COUNT_NONE) begin
                req_cycles++;
                if (o_req_addr !== addr || o_req_count !== cnt || o_req_wr_en !== wr ||
                    (wr && o_req_wr_data !== data)) req_ok = 1'b0;
            end
            if (o_done || lat >= 30) break;
            @(posedge clk); #1;
            lat++;
        end
        code = o_code; rd = o_rd_data; to = o_timeout; rdy_at_done = o_cmd_ready;
        @(posedge clk); #1;
        hold_ok = !o_done && (o_code === code) && (o_rd_data === rd) && (o_timeout === to);
    endtask

    // ------------------------------------------------------------------
    // Reference model: byte array, plain arithmetic.
    // ------------------------------------------------------------------
    logic [7:0] ref_mem [0:MEM_BYTES-1];

    task automatic model(
        input logic wr, input logic [1:0] cnt, input logic sgn,
        input logic [31:0] addr, input logic [31:0] data, input logic silent,
        output logic [2:0] code, output logic [31:0] rd, output logic to,
        output int lat, output int nreq
    );
        int     sz;
        longint v;
        code = `MEM_CODE_INVALID; rd = '0; to = 1'b0; lat = 2; nreq = 1;
        if (cnt == 2'd0) begin
            lat = 0; nreq = 0;
        end else if (silent) begin
            to = 1'b1; lat = TIMEOUT + 1;
        end else begin
            sz = (cnt == 2'd1) ? 1 : (cnt == 2'd2) ? 2 : 4;
            if (addr % sz != 0) code = `MEM_CODE_MISALIGNED;
            else if (longint'(addr) + sz > MEM_BYTES) code = `MEM_CODE_OUT_OF_BOUNDS;
            else if (wr) begin
                for (int i = 0; i < sz; i++) ref_mem[addr + i] = 8'((data >> (8 * i)) & 32'hFF);
                code = `MEM_CODE_WRITE;
            end else begin
                v = 0;
                for (int i = 0; i < sz; i++) v = v + (longint'(ref_mem[addr + i]) << (8 * i));
                if (sgn && sz < 4 && v >= (longint'(1) << (8 * sz - 1)))
                    v = v + (longint'(1) << 32) - (longint'(1) << (8 * sz));
                rd   = v[31:0];
                code = `MEM_CODE_READ;
            end
        end
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  cnt;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  ecode;
        logic [31:0] erd;
        logic        eto;
        int          elat;
        int          ereq;
    } vec_t;

    vec_t tbl [9];

    logic [2:0]  g_code, e_code;
    logic [31:0] g_rd, e_rd;
    logic        g_to, e_to, g_rdy, g_hold, g_reqok;
    int          g_lat, g_req, e_lat, e_req, k, seen;

    initial begin
        tbl[0] = '{1'b1, 2'd3, 1'b0, 32'h8,  32'hDEADBEEF, `MEM_CODE_WRITE,         32'h0,        1'b0, 2, 1};
        tbl[1] = '{1'b0, 2'd1, 1'b1, 32'hB,  32'h0,        `MEM_CODE_READ,          32'hFFFFFFDE, 1'b0, 2, 1};
        tbl[2] = '{1'b0, 2'd1, 1'b0, 32'hB,  32'h0,        `MEM_CODE_READ,          32'h000000DE, 1'b0, 2, 1};
        tbl[3] = '{1'b0, 2'd2, 1'b0, 32'hA,  32'h0,        `MEM_CODE_READ,          32'h0000DEAD, 1'b0, 2, 1};
        tbl[4] = '{1'b0, 2'd2, 1'b1, 32'h8,  32'h0,        `MEM_CODE_READ,          32'hFFFFBEEF, 1'b0, 2, 1};
        tbl[5] = '{1'b0, 2'd3, 1'b0, 32'h2,  32'h0,        `MEM_CODE_MISALIGNED,    32'h0,        1'b0, 2, 1};
        tbl[6] = '{1'b0, 2'd0, 1'b0, 32'h8,  32'h0,        `MEM_CODE_INVALID,       32'h0,        1'b0, 0, 0};
        tbl[7] = '{1'b0, 2'd3, 1'b1, 32'h8,  32'h0,        `MEM_CODE_READ,          32'hDEADBEEF, 1'b0, 2, 1};
        tbl[8] = '{1'b0, 2'd3, 1'b0, 32'h40, 32'h0,        `MEM_CODE_OUT_OF_BOUNDS, 32'h0,        1'b0, 2, 1};

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst_ready", 32'(o_cmd_ready), 32'd1);
        chk("rst_req_count", 32'(o_req_count), 32'(`MEM_COUNT_NONE));
        chk("rst_req_addr", o_req_addr, 32'h0);
        chk("rst_req_wr_en", 32'(o_req_wr_en), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_code", 32'(o_code), 32'(`MEM_CODE_INVALID));
        chk("rst_rd_data", o_rd_data, 32'h0);
        chk("rst_timeout", 32'(o_timeout), 32'd0);
        aresetn = 1'b1;

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
            run_cmd(tbl[i].wr, tbl[i].cnt, tbl[i].sgn, tbl[i].addr, tbl[i].data,
                    g_code, g_rd, g_to, g_lat, g_req, g_rdy, g_hold, g_reqok);
            chk($sformatf("vec%0d_code", i), 32'(g_code), 32'(tbl[i].ecode));
            chk($sformatf("vec%0d_rd_data", i), g_rd, tbl[i].erd);
            chk($sformatf("vec%0d_timeout", i), 32'(g_to), 32'(tbl[i].eto));
            chk($sformatf("vec%0d_latency", i), 32'(g_lat), 32'(tbl[i].elat));
            chk($sformatf("vec%0d_req_cycles", i), 32'(g_req), 32'(tbl[i].ereq));
            chk($sformatf("vec%0d_req_fields", i), 32'(g_reqok), 32'd1);
            chk($sformatf("vec%0d_ready_at_done", i), 32'(g_rdy), 32'd1);
            chk($sformatf("vec%0d_hold", i), 32'(g_hold), 32'd1);
        end

        // Timeout with a silent responder (previous result had nonzero data)
        run_cmd(1'b0, 2'd3, 1'b0, 32'h8, 32'h0, g_code, g_rd, g_to, g_lat, g_req, g_rdy, g_hold, g_reqok);
        chk("pre_to_rd_data", g_rd, 32'hDEADBEEF);
        mute = 1'b1;
        run_cmd(1'b0, 2'd3, 1'b0, 32'h8, 32'h0, g_code, g_rd, g_to, g_lat, g_req, g_rdy, g_hold, g_reqok);
        mute = 1'b0;
        chk("to_code", 32'(g_code), 32'(`MEM_CODE_INVALID));
        chk("to_rd_data", g_rd, 32'h0);
        chk("to_flag", 32'(g_to), 32'd1);
        chk("to_latency", 32'(g_lat), 32'(TIMEOUT + 1));
        chk("to_req_cycles", 32'(g_req), 32'd1);
        chk("to_ready_at_done", 32'(g_rdy), 32'd1);

        // Back-to-back with valid held high: store half then dependent load
        @(negedge clk);
        i_cmd_wr_en = 1'b1; i_cmd_count = 2'd2; i_cmd_signed = 1'b0;
        i_cmd_addr = 32'h10; i_cmd_wr_data = 32'h12345678; i_cmd_valid = 1'b1;
        @(posedge clk); #1;
        i_cmd_wr_en = 1'b0; i_cmd_count = 2'd2; i_cmd_signed = 1'b0;
        i_cmd_addr = 32'h10; i_cmd_wr_data = 32'hFFFFFFFF;
        k = 0;
        while (!o_done && k < 20) begin
            chk("b2b_req_wr_data_hold", o_req_wr_data, 32'h12345678);
            @(posedge clk); #1; k++;
        end
        chk("b2b_a_latency", 32'(k), 32'd2);
        chk("b2b_a_code", 32'(o_code), 32'(`MEM_CODE_WRITE));
        chk("b2b_a_ready", 32'(o_cmd_ready), 32'd1);
        @(posedge clk); #1;
        i_cmd_valid = 1'b0;
        chk("b2b_b_accepted", 32'(o_req_count), 32'(`MEM_COUNT_HALF));
        chk("b2b_b_req_wr_en", 32'(o_req_wr_en), 32'd0);
        chk("b2b_b_busy", 32'(o_cmd_ready), 32'd0);
        chk("b2b_done_pulse", 32'(o_done), 32'd0);
        k = 0;
        while (!o_done && k < 20) begin @(posedge clk); #1; k++; end
        chk("b2b_b_latency", 32'(k), 32'd2);
        chk("b2b_b_code", 32'(o_code), 32'(`MEM_CODE_READ));
        chk("b2b_b_rd_data", o_rd_data, 32'h00005678);

        // Reset asserted while waiting on a silent responder
        mute = 1'b1;
        @(negedge clk);
        i_cmd_wr_en = 1'b0; i_cmd_count = 2'd3; i_cmd_addr = 32'h8; i_cmd_valid = 1'b1;
        @(posedge clk); #1;
        i_cmd_valid = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        aresetn = 1'b0;
        #1;
        chk("arst_req_count", 32'(o_req_count), 32'(`MEM_COUNT_NONE));
        chk("arst_req_addr", o_req_addr, 32'h0);
        chk("arst_done", 32'(o_done), 32'd0);
        chk("arst_rd_data", o_rd_data, 32'h0);
        chk("arst_code", 32'(o_code), 32'(`MEM_CODE_INVALID));
        chk("arst_timeout", 32'(o_timeout), 32'd0);
        chk("arst_ready", 32'(o_cmd_ready), 32'd1);
        @(negedge clk);
        aresetn = 1'b1;
        mute = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (o_done) seen++;
        end
        chk("arst_no_done", 32'(seen), 32'd0);

        // Randomized commands against the reference model (memory was cleared)
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;
        for (int n = 0; n < 300; n++) begin
            logic        r_wr, r_sgn;
            logic [1:0]  r_cnt;
            logic [31:0] r_addr, r_data;
            r_wr   = 1'($urandom);
            r_sgn  = 1'($urandom);
            r_cnt  = 2'($urandom);
            r_addr = $urandom_range(0, MEM_BYTES + 7);
            r_data = $urandom;
            mute   = ($urandom_range(0, 9) == 0);
            model(r_wr, r_cnt, r_sgn, r_addr, r_data, mute, e_code, e_rd, e_to, e_lat, e_req);
            run_cmd(r_wr, r_cnt, r_sgn, r_addr, r_data, g_code, g_rd, g_to, g_lat, g_req, g_rdy, g_hold, g_reqok);
            chk("rnd_code", 32'(g_code), 32'(e_code));
            chk("rnd_rd_data", g_rd, e_rd);
            chk("rnd_timeout", 32'(g_to), 32'(e_to));
            chk("rnd_latency", 32'(g_lat), 32'(e_lat));
            chk("rnd_req_cycles", 32'(g_req), 32'(e_req));
            chk("rnd_req_fields", 32'(g_reqok), 32'd1);
            chk("rnd_ready_at_done", 32'(g_rdy), 32'd1);
            chk("rnd_hold", 32'(g_hold), 32'd1);
        end
        mute = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
